mem_bus_ctrl: RTL and testbench

MEM_BUS_CTRL -- requirements
Module: mem_bus_ctrl

---
 rtl/mem_bus_ctrl.sv | 137 +++++++++++++
 tb/tb_mem_bus_ctrl.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/mem_bus_ctrl.sv
// mem_bus_ctrl: CPU bus controller with ROM/RAM decode, wait states and a test/status register window
module mem_bus_ctrl #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 8,
  parameter int ROM_DEPTH = 256,
  parameter int RAM_DEPTH = 1024,
  parameter int WAIT_STATES = 0,
  parameter logic [ADDR_W-1:0] IO_BASE = 16'hFF00
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic              cpu_rd,
  input  logic              cpu_wr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              cpu_ready,
  input  logic              load_en,
  input  logic [ADDR_W-1:0] load_addr,
  input  logic [DATA_W-1:0] load_data,
  output logic [15:0]       pass_cnt,
  output logic [15:0]       fail_cnt,
  output logic              done,
  output logic              bus_err
);
  localparam int ROM_AW = ROM_DEPTH > 1 ? $clog2(ROM_DEPTH) : 1;
  localparam int RAM_AW = RAM_DEPTH > 1 ? $clog2(RAM_DEPTH) : 1;
  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_WAIT = 2'd1;
  localparam logic [1:0] S_ACK  = 2'd2;
  // boundaries carry one extra bit so region compares never wrap
  localparam logic [ADDR_W:0] ROM_END = (ADDR_W+1)'(ROM_DEPTH);
  localparam logic [ADDR_W:0] RAM_END = (ADDR_W+1)'(ROM_DEPTH + RAM_DEPTH);
  localparam logic [ADDR_W:0] IO0 = {1'b0, IO_BASE};
  localparam logic [3:0] WS_LAST = 4'(WAIT_STATES - 1);

  logic [1:0] state_q, state_d;
  logic [3:0] wait_cnt_q, wait_cnt_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d, rdata_q, rdata_d;
  logic rd_q, rd_d, wr_q, wr_d, err_q, err_d, done_q, done_d;
  logic [15:0] pass_cnt_q, pass_cnt_d, fail_cnt_q, fail_cnt_d;
  logic [DATA_W-1:0] rom_q [ROM_DEPTH];
  logic [DATA_W-1:0] ram_q [RAM_DEPTH];

  logic idle, req, commit, t_rd, t_wr, in_rom, in_ram, io_hit, io0, io1, io2;
  logic conflict, bad, wr_ok, ram_we, load_ok;
  logic [ADDR_W-1:0] t_addr;
  logic [ADDR_W:0] t_addr_x;
  logic [DATA_W-1:0] t_wdata, rd_val;
  logic [ROM_AW-1:0] rom_idx;
  logic [RAM_AW-1:0] ram_idx;

  // in IDLE the live bus is the transaction; in WAIT the latched copy is
  always_comb begin
    idle = state_q == S_IDLE;
    req = cpu_rd | cpu_wr;
    t_addr = idle ? cpu_addr : addr_q;
    t_wdata = idle ? cpu_wdata : wdata_q;
    t_rd = idle ? cpu_rd : rd_q;
    t_wr = idle ? cpu_wr : wr_q;
    commit = idle ? req && WAIT_STATES == 0 : state_q == S_WAIT && wait_cnt_q == WS_LAST;
    t_addr_x = {1'b0, t_addr};
    in_rom = t_addr_x < ROM_END;
    in_ram = !in_rom && t_addr_x < RAM_END;
    io_hit = !in_rom && !in_ram;
    io0 = io_hit && t_addr_x == IO0;
    io1 = io_hit && t_addr_x == IO0 + (ADDR_W+1)'(1);
    io2 = io_hit && t_addr_x == IO0 + (ADDR_W+1)'(2);
    rom_idx = ROM_AW'(t_addr);
    ram_idx = RAM_AW'(t_addr_x - ROM_END);
    conflict = t_rd && t_wr;
    bad = conflict || !(in_rom || in_ram || io0 || io1 || io2) || (t_wr && in_rom);
    rd_val = conflict ? '0 :
             in_rom   ? rom_q[rom_idx] :
             in_ram   ? ram_q[ram_idx] :
             io0      ? DATA_W'(pass_cnt_q) :
             io1      ? DATA_W'(fail_cnt_q) :
             io2      ? DATA_W'(done_q) : '0;
    wr_ok = commit && t_wr && !conflict;
    ram_we = wr_ok && in_ram;
    load_ok = load_en && {1'b0, load_addr} < ROM_END;
    state_d = idle ? (req ? (WAIT_STATES == 0 ? S_ACK : S_WAIT) : S_IDLE) :
              state_q == S_WAIT ? (commit ? S_ACK : S_WAIT) : S_IDLE;
    wait_cnt_d = state_q == S_WAIT && !commit ? wait_cnt_q + 4'd1 : 4'd0;
    addr_d = idle && req ? cpu_addr : addr_q;
    wdata_d = idle && req ? cpu_wdata : wdata_q;
    rd_d = idle && req ? cpu_rd : rd_q;
    wr_d = idle && req ? cpu_wr : wr_q;
    rdata_d = commit && t_rd ? rd_val : rdata_q;
    err_d = commit && bad;
    pass_cnt_d = wr_ok && io0 && pass_cnt_q != 16'hFFFF ? pass_cnt_q + 16'd1 : pass_cnt_q;
    fail_cnt_d = wr_ok && io1 && fail_cnt_q != 16'hFFFF ? fail_cnt_q + 16'd1 : fail_cnt_q;
    done_d = done_q | (wr_ok && io2);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
      wait_cnt_q <= '0;
      addr_q <= '0;
      wdata_q <= '0;
      rd_q <= 1'b0;
      wr_q <= 1'b0;
      rdata_q <= '0;
      err_q <= 1'b0;
      pass_cnt_q <= '0;
      fail_cnt_q <= '0;
      done_q <= 1'b0;
    end else begin
      state_q <= state_d;
      wait_cnt_q <= wait_cnt_d;
      addr_q <= addr_d;
      wdata_q <= wdata_d;
      rd_q <= rd_d;
      wr_q <= wr_d;
      rdata_q <= rdata_d;
      err_q <= err_d;
      pass_cnt_q <= pass_cnt_d;
      fail_cnt_q <= fail_cnt_d;
      done_q <= done_d;
    end
  end

  // memories keep their contents across reset; a same-edge ROM read sees the pre-load word
  always_ff @(posedge clk) begin
    if (load_ok) rom_q[ROM_AW'(load_addr)] <= load_data;
    if (ram_we) ram_q[ram_idx] <= t_wdata;
  end

  assign cpu_ready = state_q == S_ACK;
  assign cpu_rdata = rdata_q;
  assign bus_err = err_q;
  assign pass_cnt = pass_cnt_q;
  assign fail_cnt = fail_cnt_q;
  assign done = done_q;
endmodule

// File: tb/tb_mem_bus_ctrl.sv
// tb_mem_bus_ctrl: table-driven scoreboard bench running a zero-wait and a three-wait instance side by side
module tb_mem_bus_ctrl;
  logic clk = 1'b0, reset_n = 1'b1;
  logic cpu_rd = 1'b0, cpu_wr = 1'b0, load_en = 1'b0;
  logic [15:0] cpu_addr = '0, load_addr = '0;
  logic [7:0] cpu_wdata = '0, load_data = '0;
  logic [1:0] en = 2'b11;
  logic [1:0] rdy, berr, dn;
  logic [7:0] rdata [2];
  logic [15:0] pc [2];
  logic [15:0] fc [2];
  int n_pass = 0, n_total = 0;

  typedef struct {logic [7:0] rdata; logic chk_rd; logic err; int lat;} exp_t;
  typedef struct {logic rd; logic wr; logic [15:0] addr; logic [7:0] wd; logic [7:0] xrd; logic xerr;} vec_t;
  exp_t q0[$], q1[$];
  vec_t tbl[$];

  mem_bus_ctrl #(.WAIT_STATES(0)) u0 (
    .clk(clk), .reset_n(reset_n), .cpu_addr(cpu_addr), .cpu_rd(cpu_rd & en[0]), .cpu_wr(cpu_wr & en[0]),
    .cpu_wdata(cpu_wdata), .cpu_rdata(rdata[0]), .cpu_ready(rdy[0]), .load_en(load_en),
    .load_addr(load_addr), .load_data(load_data), .pass_cnt(pc[0]), .fail_cnt(fc[0]),
    .done(dn[0]), .bus_err(berr[0]));

  mem_bus_ctrl #(.WAIT_STATES(3)) u1 (
    .clk(clk), .reset_n(reset_n), .cpu_addr(cpu_addr), .cpu_rd(cpu_rd & en[1]), .cpu_wr(cpu_wr & en[1]),
    .cpu_wdata(cpu_wdata), .cpu_rdata(rdata[1]), .cpu_ready(rdy[1]), .load_en(load_en),
    .load_addr(load_addr), .load_data(load_data), .pass_cnt(pc[1]), .fail_cnt(fc[1]),
    .done(dn[1]), .bus_err(berr[1]));

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic chk_reset(input string tag);
    for (int i = 0; i < 2; i++) begin
      chk($sformatf("%s ready[%0d]", tag, i), rdy[i], 0);
      chk($sformatf("%s bus_err[%0d]", tag, i), berr[i], 0);
      chk($sformatf("%s rdata[%0d]", tag, i), rdata[i], 0);
      chk($sformatf("%s pass_cnt[%0d]", tag, i), pc[i], 0);
      chk($sformatf("%s fail_cnt[%0d]", tag, i), fc[i], 0);
      chk($sformatf("%s done[%0d]", tag, i), dn[i], 0);
    end
  endtask

  task automatic load(input logic [15:0] a, input logic [7:0] d);
    @(negedge clk);
    load_en = 1'b1; load_addr = a; load_data = d;
    @(posedge clk); #1;
    load_en = 1'b0;
  endtask

  task automatic txn(input logic rd, input logic wr, input logic [15:0] addr, input logic [7:0] wd,
                     input logic [7:0] xrd, input logic xerr, input logic [1:0] ena,
                     input logic le, input logic [15:0] la, input logic [7:0] ld);
    exp_t e;
    int at [2];
    logic [1:0] seen;
    @(negedge clk);
    en = ena; cpu_rd = rd; cpu_wr = wr; cpu_addr = addr; cpu_wdata = wd;
    load_en = le; load_addr = la; load_data = ld;
    e.rdata = xrd; e.chk_rd = rd; e.err = xerr;
    if (ena[0]) begin e.lat = 1; q0.push_back(e); end
    if (ena[1]) begin e.lat = 4; q1.push_back(e); end
    seen = ~ena;
    at = '{0, 0};
    @(posedge clk); #1;
    // scramble the bus while the wait-state instance is still busy
    cpu_rd = 1'b0; cpu_wr = 1'b0; cpu_addr = 16'h8000; cpu_wdata = 8'h00; load_en = 1'b0;
    for (int c = 1; c <= 10; c++) begin
      @(negedge clk);
      for (int i = 0; i < 2; i++) if (ena[i]) begin
        if (!seen[i] && rdy[i]) begin
          seen[i] = 1'b1;
          at[i] = c;
          if (i == 0) e = q0.pop_front(); else e = q1.pop_front();
          chk($sformatf("latency %h[%0d]", addr, i), c, e.lat);
          chk($sformatf("bus_err %h[%0d]", addr, i), berr[i], e.err);
          if (e.chk_rd) chk($sformatf("rdata %h[%0d]", addr, i), rdata[i], e.rdata);
        end else if (seen[i] && c == at[i] + 1) begin
          chk($sformatf("ready drop %h[%0d]", addr, i), rdy[i], 0);
          chk($sformatf("err drop %h[%0d]", addr, i), berr[i], 0);
        end else if (!seen[i]) begin
          chk($sformatf("err early %h[%0d]", addr, i), berr[i], 0);
        end
      end
      if (&seen && c > at[0] + 1 && c > at[1] + 1) break;
    end
    for (int i = 0; i < 2; i++) if (!seen[i]) begin
      chk($sformatf("ready timeout %h[%0d]", addr, i), rdy[i], 1);
      if (i == 0) void'(q0.pop_front()); else void'(q1.pop_front());
    end
  endtask

  initial begin
    tbl.push_back(vec_t'{1'b1, 1'b0, 16'h0000, 8'h00, 8'hA9, 1'b0});
    tbl.push_back(vec_t'{1'b0, 1'b1, 16'h0100, 8'h5A, 8'h00, 1'b0});
    tbl.push_back(vec_t'{1'b1, 1'b0, 16'h0100, 8'h00, 8'h5A, 1'b0});
    tbl.push_back(vec_t'{1'b0, 1'b1, 16'h0005, 8'hFF, 8'h00, 1'b1});
    tbl.push_back(vec_t'{1'b1, 1'b0, 16'h0005, 8'h00, 8'h55, 1'b0});
    tbl.push_back(vec_t'{1'b1, 1'b0, 16'h8000, 8'h00, 8'h00, 1'b1});
    tbl.push_back(vec_t'{1'b0, 1'b1, 16'h0200, 8'h33, 8'h00, 1'b0});
    tbl.push_back(vec_t'{1'b1, 1'b0, 16'h0200, 8'h00, 8'h33, 1'b0});
    tbl.push_back(vec_t'{1'b0, 1'b1, 16'h04FF, 8'h7E, 8'h00, 1'b0});
    tbl.push_back(vec_t'{1'b1, 1'b0, 16'h04FF, 8'h00, 8'h7E, 1'b0});
    tbl.push_back(vec_t'{1'b1, 1'b0, 16'h00FF, 8'h00, 8'hC3, 1'b0});
    tbl.push_back(vec_t'{1'b1, 1'b0, 16'h0500, 8'h00, 8'h00, 1'b1});
    tbl.push_back(vec_t'{1'b0, 1'b1, 16'h0500, 8'h12, 8'h00, 1'b1});
    tbl.push_back(vec_t'{1'b0, 1'b1, 16'hFF00, 8'hAB, 8'h00, 1'b0});
    tbl.push_back(vec_t'{1'b0, 1'b1, 16'hFF00, 8'h00, 8'h00, 1'b0});
    tbl.push_back(vec_t'{1'b0, 1'b1, 16'hFF00, 8'h77, 8'h00, 1'b0});
    tbl.push_back(vec_t'{1'b0, 1'b1, 16'hFF01, 8'hAB, 8'h00, 1'b0});
    tbl.push_back(vec_t'{1'b0, 1'b1, 16'hFF02, 8'h00, 8'h00, 1'b0});
    tbl.push_back(vec_t'{1'b1, 1'b0, 16'hFF00, 8'h00, 8'h03, 1'b0});
    tbl.push_back(vec_t'{1'b1, 1'b0, 16'hFF01, 8'h00, 8'h01, 1'b0});
    tbl.push_back(vec_t'{1'b1, 1'b0, 16'hFF02, 8'h00, 8'h01, 1'b0});
    tbl.push_back(vec_t'{1'b1, 1'b0, 16'hFF03, 8'h00, 8'h00, 1'b1});
    tbl.push_back(vec_t'{1'b1, 1'b0, 16'hFEFF, 8'h00, 8'h00, 1'b1});
    tbl.push_back(vec_t'{1'b1, 1'b1, 16'h0100, 8'h99, 8'h00, 1'b1});
    tbl.push_back(vec_t'{1'b1, 1'b0, 16'h0100, 8'h00, 8'h5A, 1'b0});
    tbl.push_back(vec_t'{1'b1, 1'b1, 16'hFF00, 8'h00, 8'h00, 1'b1});
    tbl.push_back(vec_t'{1'b1, 1'b0, 16'hFF00, 8'h00, 8'h03, 1'b0});

    #1 reset_n = 1'b0;
    #1 chk_reset("por");
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    load(16'h0000, 8'hA9);
    load(16'h0005, 8'h55);
    load(16'h00FF, 8'hC3);
    load(16'h0010, 8'h11);

    foreach (tbl[k]) txn(tbl[k].rd, tbl[k].wr, tbl[k].addr, tbl[k].wd, tbl[k].xrd, tbl[k].xerr, 2'b11, 1'b0, 16'h0, 8'h0);
    for (int i = 0; i < 2; i++) begin
      chk($sformatf("io pass_cnt[%0d]", i), pc[i], 3);
      chk($sformatf("io fail_cnt[%0d]", i), fc[i], 1);
      chk($sformatf("io done[%0d]", i), dn[i], 1);
    end

    // request held across ACK is taken again after one IDLE cycle
    @(negedge clk);
    en = 2'b01; cpu_rd = 1'b1; cpu_addr = 16'h0000;
    @(negedge clk); chk("b2b ack1", rdy[0], 1); chk("b2b rdata", rdata[0], 8'hA9);
    @(negedge clk); chk("b2b gap", rdy[0], 0);
    @(posedge clk); #1 cpu_rd = 1'b0;
    @(negedge clk); chk("b2b ack2", rdy[0], 1);
    @(negedge clk); chk("b2b end", rdy[0], 0);

    txn(1'b1, 1'b0, 16'h0010, 8'h00, 8'h11, 1'b0, 2'b01, 1'b1, 16'h0010, 8'h22);
    txn(1'b1, 1'b0, 16'h0010, 8'h00, 8'h22, 1'b0, 2'b11, 1'b0, 16'h0, 8'h0);
    txn(1'b1, 1'b0, 16'h0100, 8'h00, 8'h5A, 1'b0, 2'b11, 1'b1, 16'h0100, 8'h77);
    txn(1'b1, 1'b0, 16'h0000, 8'h00, 8'hA9, 1'b0, 2'b11, 1'b0, 16'h0, 8'h0);

    // reset pulse in the second wait cycle aborts the RAM write
    @(negedge clk);
    en = 2'b10; cpu_wr = 1'b1; cpu_addr = 16'h0200; cpu_wdata = 8'hEE;
    @(posedge clk); #1;
    cpu_wr = 1'b0; cpu_addr = 16'h0000; cpu_wdata = 8'h00;
    @(posedge clk); #3 reset_n = 1'b0;
    #1 chk_reset("wait abort");
    #2 reset_n = 1'b1;
    repeat (6) begin
      @(negedge clk);
      chk("abort no ready", rdy[1], 0);
    end
    txn(1'b1, 1'b0, 16'h0200, 8'h00, 8'h33, 1'b0, 2'b11, 1'b0, 16'h0, 8'h0);
    txn(1'b1, 1'b0, 16'h0000, 8'h00, 8'hA9, 1'b0, 2'b11, 1'b0, 16'h0, 8'h0);

    @(negedge clk);
    force u0.pass_cnt_q = 16'hFFFE;
    force u1.pass_cnt_q = 16'hFFFE;
    @(posedge clk);
    @(negedge clk);
    release u0.pass_cnt_q;
    release u1.pass_cnt_q;
    txn(1'b0, 1'b1, 16'hFF00, 8'h00, 8'h00, 1'b0, 2'b11, 1'b0, 16'h0, 8'h0);
    for (int i = 0; i < 2; i++) chk($sformatf("sat reach[%0d]", i), pc[i], 16'hFFFF);
    txn(1'b0, 1'b1, 16'hFF00, 8'h00, 8'h00, 1'b0, 2'b11, 1'b0, 16'h0, 8'h0);
    for (int i = 0; i < 2; i++) chk($sformatf("sat hold[%0d]", i), pc[i], 16'hFFFF);
    txn(1'b1, 1'b1, 16'hFF01, 8'h00, 8'h00, 1'b1, 2'b11, 1'b0, 16'h0, 8'h0);
    txn(1'b1, 1'b1, 16'hFF02, 8'h00, 8'h00, 1'b1, 2'b11, 1'b0, 16'h0, 8'h0);
    for (int i = 0; i < 2; i++) begin
      chk($sformatf("rdwr fail_cnt[%0d]", i), fc[i], 0);
      chk($sformatf("rdwr done[%0d]", i), dn[i], 0);
      chk($sformatf("rdwr pass_cnt[%0d]", i), pc[i], 16'hFFFF);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
